seq_alu_exec: RTL

- Execute-side consumer of the 4-bit ALUControl encoding produced by the ALU decoder; the receiving end of that interface.
- Accepts operands plus a control code over a valid/ready handshake and computes the result.
- Returns the result and a zero flag over a second valid/ready handshake.
- Add/sub/logic/compare complete in one cycle; shifts run iteratively, one bit per cycle, so the datapath holds no barrel shifter (area build for the multicycle core variant).

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_shift_unit.sv | 69 ++++++
 rtl/seq_alu_exec.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALUControl encoding, execute FSM states and decode helpers for the ALU decoder/executor.
package alu_pkg;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSlt  = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluSll  = 4'b0111;
  localparam logic [3:0] AluSrl  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluSltu = 4'b1100;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == AluSll) || (ctrl == AluSrl) || (ctrl == AluSra);
  endfunction

  function automatic logic is_legal(input logic [3:0] ctrl);
    logic legal;
    case (ctrl)
      AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluXor,
      AluSll, AluSrl, AluSra, AluSltu: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Shift engine: one bit per cycle by default; combinational barrel shift when
// SEQ_ALU_FAST_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
`ifndef SEQ_ALU_FAST_SHIFT_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
`endif
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] dout
);

`ifdef SEQ_ALU_FAST_SHIFT_EN

  always_comb begin
    case (op)
      AluSrl:  dout = din >> shamt;
      AluSra:  dout = $unsigned($signed(din) >>> shamt);
      default: dout = din << shamt;
    endcase
  end

`else

  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_shifted;

  always_comb begin
    case (op_q)
      AluSrl:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
      AluSra:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
    endcase
  end

  assign busy = (cnt_q != '0);
  // Final step: the value shifted this cycle is the answer, hand it out directly.
  assign done = busy && (cnt_q == SHW'(1));
  assign dout = acc_shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
      op_q  <= AluSll;
    end else if (start) begin
      acc_q <= din;
      cnt_q <= shamt;
      op_q  <= op;
    end else if (busy) begin
      acc_q <= acc_shifted;
      cnt_q <= cnt_q - 1'b1;
    end
  end

`endif

endmodule

// File: rtl/seq_alu_exec.sv
// Execute-side ALU with valid/ready request and response handshakes.
// Define SEQ_ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
module seq_alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] sh_dout;

`ifdef SEQ_ALU_FAST_SHIFT_EN
  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .op    (alu_ctrl),
    .din   (src_a),
    .shamt (src_b[SHW-1:0]),
    .dout  (sh_dout)
  );
`else
  logic sh_start, sh_busy, sh_done;

  alu_shift_unit #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .clk   (clk),
    .reset (reset),
    .start (sh_start),
    .busy  (sh_busy),
    .done  (sh_done),
    .op    (alu_ctrl),
    .din   (src_a),
    .shamt (src_b[SHW-1:0]),
    .dout  (sh_dout)
  );
`endif

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      AluAdd:  alu_res = src_a + src_b;
      AluSub:  alu_res = src_a - src_b;
      AluAnd:  alu_res = src_a & src_b;
      AluOr:   alu_res = src_a | src_b;
      AluXor:  alu_res = src_a ^ src_b;
      AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
`ifdef SEQ_ALU_FAST_SHIFT_EN
      AluSll, AluSrl, AluSra: alu_res = sh_dout;
`else
      // Only the zero-amount case completes here; longer shifts go through StShift.
      AluSll, AluSrl, AluSra: alu_res = src_a;
`endif
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifndef SEQ_ALU_FAST_SHIFT_EN
    sh_start  = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
`ifndef SEQ_ALU_FAST_SHIFT_EN
          if (is_shift(alu_ctrl) && (src_b[SHW-1:0] != '0)) begin
            sh_start = 1'b1;
            state_d  = StShift;
          end else
`endif
          begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = !is_legal(alu_ctrl);
            state_d   = StDone;
          end
        end
      end
      StShift: begin
`ifndef SEQ_ALU_FAST_SHIFT_EN
        if (sh_done) begin
          result_d  = sh_dout;
          zero_d    = (sh_dout == '0);
          illegal_d = 1'b0;
          state_d   = StDone;
        end else if (!sh_busy) begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
